// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shift/rotate mode encoding shared by the shifter and the ALU
package shifter_pkg;

    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRA = 2'b01,
        MODE_ROR = 2'b10,
        MODE_SRL = 2'b11
    } shift_mode_e;

endpackage

// File: rtl/shift_stage.sv
// rtl/shift_stage.sv - one barrel-shifter level (shift by STEP) with its pipeline register
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     up_valid,
    input  logic [WIDTH-1:0]         up_data,
    input  logic [$clog2(WIDTH)-1:0] up_amt,
    input  logic [1:0]               up_mode,
    input  logic                     down_adv,
    output logic                     adv,
    output logic                     valid,
    output logic [WIDTH-1:0]         data,
    output logic [$clog2(WIDTH)-1:0] amt,
    output logic [1:0]               mode
);

    localparam int AMT_BIT = $clog2(STEP);

    logic [WIDTH-1:0] shifted;

    always_comb begin
        shifted = up_data;
        if (up_amt[AMT_BIT]) begin
            case (up_mode)
                MODE_SLL: shifted = {up_data[WIDTH-1-STEP:0], {STEP{1'b0}}};
                MODE_SRA: shifted = {{STEP{up_data[WIDTH-1]}}, up_data[WIDTH-1:STEP]};
                MODE_ROR: shifted = {up_data[STEP-1:0], up_data[WIDTH-1:STEP]};
                default:  shifted = {{STEP{1'b0}}, up_data[WIDTH-1:STEP]};
            endcase
        end
    end

    // A stage may load when it holds nothing or its content moves on this cycle.
    assign adv = !valid || down_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            amt   <= '0;
            mode  <= 2'b00;
        end else if (adv) begin
            valid <= up_valid;
            if (up_valid) begin
                data <= shifted;
                amt  <= up_amt;
                mode <= up_mode;
            end
        end
    end

endmodule

// File: rtl/pipe_shifter.sv
// rtl/pipe_shifter.sv - log2(WIDTH)-stage pipelined shifter/rotator with valid/ready handshakes
module pipe_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_amt,
    input  logic [1:0]               in_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_zero,
    output logic                     out_neg
);

    localparam int SHW = $clog2(WIDTH);

    // Index 0 is the input port; index k+1 is the register of stage k.
    logic [SHW:0]            v;
    logic [SHW:0][WIDTH-1:0] d;
    logic [SHW:0][SHW-1:0]   a;
    logic [SHW:0][1:0]       m;
    logic [SHW:0]            rdy;

    assign v[0]     = in_valid;
    assign d[0]     = in_data;
    assign a[0]     = in_amt;
    assign m[0]     = in_mode;
    assign rdy[SHW] = out_ready;

    generate
        for (genvar k = 0; k < SHW; k++) begin : g_stage
            shift_stage #(
                .WIDTH (WIDTH),
                .STEP  (1 << k)
            ) u_stage (
                .clk      (clk),
                .rst_n    (rst_n),
                .up_valid (v[k]),
                .up_data  (d[k]),
                .up_amt   (a[k]),
                .up_mode  (m[k]),
                .down_adv (rdy[k+1]),
                .adv      (rdy[k]),
                .valid    (v[k+1]),
                .data     (d[k+1]),
                .amt      (a[k+1]),
                .mode     (m[k+1])
            );
        end
    endgenerate

    assign in_ready  = rdy[0];
    assign out_valid = v[SHW];
    assign out_data  = d[SHW];
    assign out_zero  = (d[SHW] == '0);
    assign out_neg   = d[SHW][WIDTH-1];

    // Amount and mode are spent once the last level has been applied.
    logic unused_tail;
    assign unused_tail = ^{a[SHW], m[SHW]};

endmodule

// File: doc/pipe_shifter.md
PIPE_SHIFTER -- requirements
Module: pipe_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data width; power of two, 4 to 64.
REQ-002 SHALL have derived localparam SHW = log2(WIDTH): shift-amount width and pipeline depth.
REQ-003 SHALL have port clk  input  1: single clock, rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1: an operand is offered.
REQ-006 SHALL have port in_ready  output  1: the operand is accepted this cycle.
REQ-007 SHALL have port in_data  input  WIDTH: value to shift.
REQ-008 SHALL have port in_amt  input  SHW: shift amount.
REQ-009 SHALL have port in_mode  input  2: operation; 00 SLL, 01 SRA, 10 ROR, 11 SRL.
REQ-010 SHALL have port out_valid  output  1: result is present.
REQ-011 SHALL have port out_ready  input  1: consumer takes the result.
REQ-012 SHALL have port out_data  output  WIDTH: shifted result.
REQ-013 SHALL have port out_zero  output  1: out_data equals 0.
REQ-014 SHALL have port out_neg  output  1: out_data[WIDTH-1].

Function
REQ-015 SHALL transfer on the input side when in_valid && in_ready, and on the output side when out_valid && out_ready.
REQ-016 SHALL have SHW register stages; stage k applies shift 2^k when amt[k]=1 and passes the value unchanged otherwise.
- Stage order: LSB stage first.
- Data, remaining amt bits and mode travel with a per-stage valid bit.
REQ-017 SHALL give SLL zero fill from the right.
REQ-018 SHALL give SRA replication of bit WIDTH-1 of the stage input.
REQ-019 SHALL give SRL zero fill from the left.
REQ-020 SHALL give ROR the bits shifted out re-entering at the MSB end.
REQ-021 SHALL have latency exactly SHW cycles from input transfer to out_valid when out_ready is held high (WIDTH=16: 4 cycles).
REQ-022 SHALL sustain throughput of one transfer per cycle with out_ready high.
REQ-023 SHALL advance stage k when it is empty or stage k+1 advances in the same cycle; bubbles collapse.
REQ-024 SHALL drive in_ready = !v0 || stage0 advances; in_ready is combinational from out_ready, and there is no combinational path from in_* to out_*.
REQ-025 SHALL hold out_data, out_zero and out_neg stable while out_valid && !out_ready.
REQ-026 SHALL accept an input and emit an output in the same cycle when the pipeline is full and out_ready=1.
REQ-027 SHALL pass in_data unchanged for amt=0 in every mode.
REQ-028 SHALL take out_zero and out_neg from the final-stage register, not from a separate flag pipeline.

Reset
REQ-029 SHALL clear all stage valid bits asynchronously while rst_n=0, giving out_valid=0 and in_ready=1 from the first clock after release.
REQ-030 SHALL drive out_data=0, out_zero=1 and out_neg=0 during reset.
REQ-031 SHALL discard in-flight operands on reset mid-operation, with no output after release until a new input transfer.

Structure
REQ-032 SHALL place the mode encoding (MODE_SLL, MODE_SRA, MODE_ROR, MODE_SRL) in shared package shifter_pkg, also used by the ALU.
REQ-033 SHALL instantiate sub-module shift_stage SHW times via generate.
- shift_stage parameters: WIDTH, STEP.
- shift_stage content: one combinational shift level plus its valid/data/amt/mode register and advance logic.

Verification
REQ-034 SHALL cover WIDTH=16, out_ready=1: in 0x8001 amt 1 mode SLL -> 0x0002 after 4 cycles, zero=0, neg=0.
REQ-035 SHALL cover SRA 0x8000 amt 15 -> 0xFFFF, neg=1.
REQ-036 SHALL cover SRL 0x8000 amt 15 -> 0x0001.
REQ-037 SHALL cover ROR 0x1234 amt 4 -> 0x4123.
REQ-038 SHALL cover back-to-back stream of 8 ops with out_ready=1 -> 8 results on 8 consecutive cycles, in order.
REQ-039 SHALL cover backpressure: fill 4 ops, hold out_ready=0 for 5 cycles -> in_ready=0 after pipe full, out_data stable, nothing lost or duplicated after release.
REQ-040 SHALL cover reset mid-stream: 3 ops in flight, rst_n low 1 cycle -> out_valid=0, in_ready=1 after release, none of the 3 ops emitted.
REQ-041 SHALL cover WIDTH=32: SLL 0x00000001 amt 31 -> 0x80000000 after 5 cycles.
